// File: rtl/touch_key_debounce_pkg.sv
// Shared definitions for the touch-key conditioning blocks: FSM states and
// the ms-to-cycles conversion reused by other key/LED blocks.
package touch_key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_e;

  // Whole clocks per ms first, so the result matches CYC_PER_MS*ms exactly.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                            input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/touch_key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reset value selectable
// so the idle pad level can be loaded during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/touch_key_debounce.sv
// Touch-key conditioner: synchronise, debounce, and emit a clean level plus
// single-cycle press / release / long-press pulses. All outputs registered.
import touch_key_debounce_pkg::*;

module touch_key_debounce #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DB_CYC   = ms_to_cyc(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cyc(CLK_FREQ_HZ, LONG_MS);
  localparam int unsigned DB_W     = $clog2(DB_CYC + 1);
  localparam int unsigned LONG_W   = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYC);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYC - 1);
  localparam logic              IDLE_RAW = (ACTIVE_HIGH == 0);

  logic       raw_s;
  logic       k_s;

  sync_2ff #(.RST_VAL(IDLE_RAW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (raw_s)
  );

  assign k_s = (ACTIVE_HIGH != 0) ? raw_s : ~raw_s;

  key_state_e        state, state_nxt;
  logic [DB_W-1:0]   db_cnt, db_nxt, db_inc;
  logic [LONG_W-1:0] long_cnt, long_nxt, long_inc;
  logic              long_hit;
  logic              level_nxt, press_nxt, rel_nxt, long_p_nxt;

  // Saturating increments; counters never wrap.
  assign db_inc   = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_W'(1);
  assign long_inc = (long_cnt == LONG_MAX) ? long_cnt : long_cnt + LONG_W'(1);
  assign long_hit = (long_cnt == LONG_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      db_cnt      <= '0;
      long_cnt    <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_nxt;
      long_cnt    <= long_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= rel_nxt;
      key_long    <= long_p_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_nxt     = db_cnt;
    long_nxt   = long_cnt;
    level_nxt  = key_level;
    press_nxt  = 1'b0;
    rel_nxt    = 1'b0;
    long_p_nxt = 1'b0;
    case (state)
      IDLE: begin
        level_nxt = 1'b0;
        long_nxt  = '0;
        if (k_s) begin
          state_nxt = PRESS_WAIT;
          db_nxt    = DB_W'(1);
        end else begin
          db_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!k_s) begin
          state_nxt = IDLE;
          db_nxt    = '0;
        end else if (db_cnt == DB_MAX) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
          long_nxt  = '0;
          db_nxt    = '0;
        end else begin
          db_nxt = db_inc;
        end
      end
      PRESSED: begin
        long_nxt   = long_inc;
        long_p_nxt = long_hit;
        if (!k_s) begin
          state_nxt = REL_WAIT;
          db_nxt    = DB_W'(1);
        end
      end
      REL_WAIT: begin
        // Bounce during release keeps the same press alive, long count included.
        long_nxt = long_inc;
        if (k_s) begin
          state_nxt  = PRESSED;
          db_nxt     = '0;
          long_p_nxt = long_hit;
        end else if (db_cnt == DB_MAX) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
          level_nxt = 1'b0;
          long_nxt  = '0;
          db_nxt    = '0;
        end else begin
          db_nxt     = db_inc;
          long_p_nxt = long_hit;
        end
      end
      default: begin
        state_nxt = IDLE;
        db_nxt    = '0;
        long_nxt  = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_touch_key_debounce.sv
// Scoreboard bench for touch_key_debounce with DB_CYC=4, LONG_CYC=20.
module tb_touch_key_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int LAT  = DB + 2;
  localparam int EV_PRESS = 1, EV_REL = 2, EV_LONG = 4;

  typedef struct {
    int cyc;
    int ev;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b0;
  logic key_level, key_press, key_release, key_long;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   mon_act;
  exp_t mon_e;

  touch_key_debounce #(
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .ACTIVE_HIGH (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  // Returns at 1 time unit after the edge where cyc reaches c.
  task automatic at_cyc(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  // Drive key at the negedge; returns the cyc value of the sampling edge.
  task automatic drive_key(input logic v, output int base);
    @(negedge clk);
    key_in = v;
    base = cyc + 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && (key_press || key_release || key_long)) begin
      mon_act = int'({key_long, key_release, key_press});
      if (sb.size() == 0) begin
        chk("unexpected_pulse", mon_act, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", mon_act, mon_e.ev);
        chk("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", int'(key_level), 0);
    chk("rst_press", int'(key_press), 0);
    chk("rst_release", int'(key_release), 0);
    chk("rst_long", int'(key_long), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Clean short press: press at +6, release 6 after fall, no long.
    drive_key(1'b1, b);
    push(b + LAT, EV_PRESS);
    at_cyc(b + LAT - 1);
    chk("t1_level_before", int'(key_level), 0);
    at_cyc(b + LAT);
    chk("t1_level_at_press", int'(key_level), 1);
    at_cyc(b + 9);
    drive_key(1'b0, r);
    chk("t1_fall_cycle", r - b, 10);
    push(r + LAT, EV_REL);
    at_cyc(r + LAT - 1);
    chk("t1_level_hold", int'(key_level), 1);
    at_cyc(r + LAT);
    chk("t1_level_released", int'(key_level), 0);
    at_cyc(r + LAT + 4);
    chk("t1_sb_drain", sb.size(), 0);

    // Bounce 1,0,1,0 then stays high: one press after the final rise.
    for (int i = 0; i < 4; i++) drive_key((i % 2) == 0, b);
    drive_key(1'b1, b);
    push(b + LAT, EV_PRESS);
    at_cyc(b + LAT);
    chk("t2_level", int'(key_level), 1);
    drive_key(1'b0, r);
    push(r + LAT, EV_REL);
    at_cyc(r + LAT + 4);
    chk("t2_sb_drain", sb.size(), 0);

    // 3-cycle glitch: nothing at all.
    drive_key(1'b1, b);
    at_cyc(b + 2);
    drive_key(1'b0, r);
    at_cyc(r + 3);
    chk("t3_level_mid", int'(key_level), 0);
    at_cyc(r + 12);
    chk("t3_level_end", int'(key_level), 0);
    chk("t3_sb_drain", sb.size(), 0);

    // Long press held 30 cycles.
    drive_key(1'b1, b);
    push(b + LAT, EV_PRESS);
    push(b + LAT + LONG, EV_LONG);
    at_cyc(b + LAT + LONG);
    chk("t4_level_long", int'(key_level), 1);
    at_cyc(b + 29);
    drive_key(1'b0, r);
    push(r + LAT, EV_REL);
    at_cyc(r + LAT + 4);
    chk("t4_level_end", int'(key_level), 0);
    chk("t4_sb_drain", sb.size(), 0);

    // Release part way through the long count: long_cnt discarded.
    drive_key(1'b1, b);
    push(b + LAT, EV_PRESS);
    at_cyc(b + 17);
    drive_key(1'b0, r);
    push(r + LAT, EV_REL);
    at_cyc(b + LAT + LONG + 6);
    chk("t5_sb_drain", sb.size(), 0);

    // Reset in cycle 8 with key held, then full debounce again.
    drive_key(1'b1, b);
    push(b + LAT, EV_PRESS);
    at_cyc(b + 8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", int'(key_level), 0);
    chk("t6_rst_outs", int'({key_long, key_release, key_press}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc + 1;
    push(r + LAT, EV_PRESS);
    at_cyc(r + LAT - 1);
    chk("t6_level_before", int'(key_level), 0);
    at_cyc(r + LAT);
    chk("t6_level_after", int'(key_level), 1);

    // Reset while the release pulse is high.
    drive_key(1'b0, r);
    push(r + LAT, EV_REL);
    at_cyc(r + LAT);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_mid_pulse", int'(key_release), 0);
    @(negedge clk);
    rst_n = 1'b1;
    at_cyc(cyc + 10);
    chk("t7_sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
